// File: rtl/rf_exec_sequencer.sv
// rtl/rf_exec_sequencer.sv - execute/writeback sequencer for the 4x32 2R1W register file
// Optional shift-add multiplier built when RF_EXEC_MUL_EN is defined; otherwise opcode 110 is illegal.
module rf_exec_sequencer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    output logic [ADDR_W-1:0] rf_raddr1,
    output logic [ADDR_W-1:0] rf_raddr2,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              rf_we,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] last_result
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;

    // S_ARM loads the write-port flops so that S_WB presents a clean, purely registered strobe.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_EXEC = 3'd2,
        S_MUL  = 3'd3,
        S_ARM  = 3'd4,
        S_WB   = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic [2:0]        op_q;
    logic [ADDR_W-1:0] rd_q;
    logic [ADDR_W-1:0] rf_raddr1_q, rf_raddr2_q;
    logic [DATA_W-1:0] op1_q, op2_q;
    logic [DATA_W-1:0] result_q;
    logic [ADDR_W-1:0] rf_waddr_q;
    logic [DATA_W-1:0] rf_wdata_q;
    logic              rf_we_q;
    logic              err_q;
    logic [DATA_W-1:0] last_result_q;
    logic [DATA_W-1:0] alu_d;
    logic              illegal_op;

`ifdef RF_EXEC_MUL_EN
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    logic [DATA_W-1:0] mcand_q, mplier_q;
    logic [CNT_W-1:0]  cnt_q;
`endif

    always_comb begin
        illegal_op = 1'b0;
        if (op_q == 3'b111) begin
            illegal_op = 1'b1;
        end
`ifndef RF_EXEC_MUL_EN
        if (op_q == OP_MUL) begin
            illegal_op = 1'b1;
        end
`endif
    end

    // MUL yields zero here so the accumulator starts cleared when EXEC loads result_q.
    always_comb begin
        alu_d = '0;
        case (op_q)
            OP_ADD:  alu_d = op1_q + op2_q;
            OP_SUB:  alu_d = op1_q - op2_q;
            OP_AND:  alu_d = op1_q & op2_q;
            OP_OR:   alu_d = op1_q | op2_q;
            OP_XOR:  alu_d = op1_q ^ op2_q;
            OP_SLL:  alu_d = op1_q << op2_q[4:0];
            default: alu_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                state_d = illegal_op ? S_IDLE : S_EXEC;
            end
            S_EXEC: begin
`ifdef RF_EXEC_MUL_EN
                state_d = (op_q == OP_MUL) ? S_MUL : S_ARM;
`else
                state_d = S_ARM;
`endif
            end
`ifdef RF_EXEC_MUL_EN
            S_MUL: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_ARM;
                end
            end
`endif
            S_ARM:   state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q          <= '0;
            rd_q          <= '0;
            rf_raddr1_q   <= '0;
            rf_raddr2_q   <= '0;
            op1_q         <= '0;
            op2_q         <= '0;
            result_q      <= '0;
            rf_waddr_q    <= '0;
            rf_wdata_q    <= '0;
            rf_we_q       <= 1'b0;
            err_q         <= 1'b0;
            last_result_q <= '0;
        end else begin
            if (state_q == S_IDLE && in_valid) begin
                op_q        <= in_op;
                rd_q        <= in_rd;
                rf_raddr1_q <= in_rs1;
                rf_raddr2_q <= in_rs2;
            end
            if (state_q == S_READ) begin
                op1_q <= rf_rdata1;
                op2_q <= rf_rdata2;
            end
            err_q <= (state_q == S_READ) && illegal_op;
            if (state_q == S_EXEC) begin
                result_q <= alu_d;
            end
`ifdef RF_EXEC_MUL_EN
            if (state_q == S_MUL && mplier_q[0]) begin
                result_q <= result_q + mcand_q;
            end
`endif
            rf_we_q <= (state_q == S_ARM);
            if (state_q == S_ARM) begin
                rf_waddr_q <= rd_q;
                rf_wdata_q <= result_q;
            end
            if (state_q == S_WB) begin
                last_result_q <= rf_wdata_q;
            end
        end
    end

`ifdef RF_EXEC_MUL_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else if (state_q == S_EXEC) begin
            mcand_q  <= op1_q;
            mplier_q <= op2_q;
            cnt_q    <= '0;
        end else if (state_q == S_MUL) begin
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
        end
    end
`endif

    // in_ready is masked by reset so every output reads zero while reset is held.
    assign in_ready    = (state_q == S_IDLE) && !reset;
    assign busy        = (state_q != S_IDLE);
    assign rf_raddr1   = rf_raddr1_q;
    assign rf_raddr2   = rf_raddr2_q;
    assign rf_waddr    = rf_waddr_q;
    assign rf_wdata    = rf_wdata_q;
    assign rf_we       = rf_we_q;
    assign done        = rf_we_q;
    assign err         = err_q;
    assign last_result = last_result_q;

endmodule
